// File: rtl/pwm_pkg.sv
// Shared encodings for the PWM carrier generator: carrier count modes and
// sync event selection.
package pwm_pkg;

    typedef enum logic [1:0] {
        MODE_STOP   = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_UPDOWN = 2'b11
    } count_mode_e;

    typedef enum logic [1:0] {
        SYNC_NONE = 2'b00,
        SYNC_ZERO = 2'b01,
        SYNC_MAX  = 2'b10,
        SYNC_BOTH = 2'b11
    } sync_mode_e;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable prescaler: o_tick fires once every i_presc+1 enabled cycles.
// i_clr restarts the count; with i_ce low the count is frozen.
module pwm_prescaler #(
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_ce,
    input  logic                   i_clr,
    input  logic [PRESC_WIDTH-1:0] i_presc,
    output logic                   o_tick
);

    logic [PRESC_WIDTH-1:0] r_cnt;

    // >= keeps the divider from running through the full range if presc shrinks mid-count.
    assign o_tick = i_ce && (r_cnt >= i_presc);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_ce) begin
            r_cnt <= o_tick ? '0 : r_cnt + PRESC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pwm_carrier_gen.sv
// PWM carrier generator: up/down/up-down counter with shadowed period and mode,
// prescaled ticks, clamped phase preload, zero/max events and a divided sync pulse.
module pwm_carrier_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int PRESC_WIDTH = 8,
    parameter int EVDIV_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ce,
    input  logic [WIDTH-1:0]       countmax,
    input  logic [1:0]             count_mode,
    input  logic [PRESC_WIDTH-1:0] presc,
    input  logic [WIDTH-1:0]       phase,
    input  logic                   phase_ld,
    input  logic [1:0]             sync_mode,
    input  logic [EVDIV_WIDTH-1:0] ev_div,
    output logic [WIDTH-1:0]       carrier,
    output logic                   dir,
    output logic                   zero_evt,
    output logic                   max_evt,
    output logic                   sync
);

    logic [WIDTH-1:0]       r_cnt;
    logic [WIDTH-1:0]       r_cmax_sh;
    count_mode_e            r_mode_sh;
    logic                   r_dir;
    logic                   r_zero_evt;
    logic                   r_max_evt;
    logic                   r_sync;
    logic [EVDIV_WIDTH-1:0] r_evcnt;

    count_mode_e            w_mode_in;
    sync_mode_e             w_sync_in;
    logic                   w_stop;
    logic                   w_start;
    logic                   w_tick;
    logic [WIDTH-1:0]       w_phase_clamped;
    logic [WIDTH-1:0]       w_next;
    logic                   w_next_dir;
    logic                   w_zero_hit;
    logic                   w_max_hit;
    logic                   w_sel;

    assign w_mode_in = count_mode_e'(count_mode);
    assign w_sync_in = sync_mode_e'(sync_mode);

    // A cleared shadow mode marks STOP, so leaving it always reloads both shadows.
    assign w_stop  = (w_mode_in == MODE_STOP) || (r_mode_sh == MODE_STOP) || (r_cmax_sh == '0);
    assign w_start = w_stop && (w_mode_in != MODE_STOP) && (countmax != '0);

    assign w_phase_clamped = (phase > r_cmax_sh) ? r_cmax_sh : phase;

    pwm_prescaler #(
        .PRESC_WIDTH(PRESC_WIDTH)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_ce   (ce),
        .i_clr  (ce && (w_stop || phase_ld)),
        .i_presc(presc),
        .o_tick (w_tick)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next     = r_cnt;
        w_next_dir = r_dir;
        case (r_mode_sh)
            MODE_UP: begin
                w_next_dir = 1'b1;
                w_next     = (r_cnt >= r_cmax_sh) ? '0 : r_cnt + WIDTH'(1);
            end
            MODE_DOWN: begin
                w_next_dir = 1'b0;
                w_next     = (r_cnt == '0) ? r_cmax_sh : r_cnt - WIDTH'(1);
            end
            MODE_UPDOWN: begin
                if (r_dir) begin
                    if (r_cnt >= r_cmax_sh) begin
                        w_next_dir = 1'b0;
                        w_next     = r_cnt - WIDTH'(1);
                    end else begin
                        w_next = r_cnt + WIDTH'(1);
                    end
                end else begin
                    if (r_cnt == '0) begin
                        w_next_dir = 1'b1;
                        w_next     = r_cnt + WIDTH'(1);
                    end else begin
                        w_next = r_cnt - WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_zero_hit = (w_next == '0);
    assign w_max_hit  = (w_next == r_cmax_sh);
    assign w_sel      = (w_zero_hit && (w_sync_in == SYNC_ZERO || w_sync_in == SYNC_BOTH)) ||
                        (w_max_hit  && (w_sync_in == SYNC_MAX  || w_sync_in == SYNC_BOTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_cmax_sh  <= '0;
            r_mode_sh  <= MODE_STOP;
            r_dir      <= 1'b1;
            r_zero_evt <= 1'b0;
            r_max_evt  <= 1'b0;
            r_sync     <= 1'b0;
            r_evcnt    <= '0;
        end else begin
            r_zero_evt <= 1'b0;
            r_max_evt  <= 1'b0;
            r_sync     <= 1'b0;
            if (ce) begin
                if (w_stop) begin
                    r_evcnt <= '0;
                    if (w_start) begin
                        r_cmax_sh <= countmax;
                        r_mode_sh <= w_mode_in;
                        r_cnt     <= (w_mode_in == MODE_DOWN) ? countmax : '0;
                        r_dir     <= (w_mode_in != MODE_DOWN);
                    end else begin
                        r_cnt     <= '0;
                        r_dir     <= 1'b1;
                        r_mode_sh <= MODE_STOP;
                    end
                end else if (phase_ld) begin
                    r_cnt <= w_phase_clamped;
                end else if (w_tick) begin
                    r_cnt      <= w_next;
                    r_dir      <= w_next_dir;
                    r_zero_evt <= w_zero_hit;
                    r_max_evt  <= w_max_hit;
                    // Period boundary: the new period runs on freshly sampled settings.
                    if (w_zero_hit) begin
                        r_cmax_sh <= countmax;
                        r_mode_sh <= w_mode_in;
                    end
                    if (w_sel) begin
                        if (r_evcnt >= ev_div) begin
                            r_sync  <= 1'b1;
                            r_evcnt <= '0;
                        end else begin
                            r_evcnt <= r_evcnt + EVDIV_WIDTH'(1);
                        end
                    end
                end
                if (w_sync_in == SYNC_NONE) begin
                    r_evcnt <= '0;
                end
            end
        end
    end

    assign carrier  = r_cnt;
    assign dir      = r_dir;
    assign zero_evt = r_zero_evt;
    assign max_evt  = r_max_evt;
    assign sync     = r_sync;

endmodule

// File: tb/tb_pwm_carrier_gen.sv
// Directed vector bench for pwm_carrier_gen: one table of per-cycle inputs with
// hand-computed outputs, plus an asynchronous reset sequence mid-count.
module tb_pwm_carrier_gen;

    localparam int W  = 16;
    localparam int PW = 8;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ce;
    logic [W-1:0]  countmax;
    logic [1:0]    count_mode;
    logic [PW-1:0] presc;
    logic [W-1:0]  phase;
    logic          phase_ld;
    logic [1:0]    sync_mode;
    logic [EW-1:0] ev_div;
    logic [W-1:0]  carrier;
    logic          dir;
    logic          zero_evt;
    logic          max_evt;
    logic          sync;

    pwm_carrier_gen #(
        .WIDTH      (W),
        .PRESC_WIDTH(PW),
        .EVDIV_WIDTH(EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .countmax  (countmax),
        .count_mode(count_mode),
        .presc     (presc),
        .phase     (phase),
        .phase_ld  (phase_ld),
        .sync_mode (sync_mode),
        .ev_div    (ev_div),
        .carrier   (carrier),
        .dir       (dir),
        .zero_evt  (zero_evt),
        .max_evt   (max_evt),
        .sync      (sync)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic          ce;
        logic [1:0]    mode;
        logic [W-1:0]  cmax;
        logic [PW-1:0] presc;
        logic          ld;
        logic [W-1:0]  phase;
        logic [1:0]    smode;
        logic [EW-1:0] evdiv;
        logic [W-1:0]  car;
        logic          dir;
        logic          z;
        logic          m;
        logic          s;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void add(string tag, int v_ce, int v_mode, int v_cmax, int v_presc,
                                int v_ld, int v_phase, int v_smode, int v_evdiv,
                                int e_car, int e_dir, int e_z, int e_m, int e_s);
        vec_t v;
        v.tag   = tag;
        v.ce    = 1'(v_ce);
        v.mode  = 2'(v_mode);
        v.cmax  = W'(v_cmax);
        v.presc = PW'(v_presc);
        v.ld    = 1'(v_ld);
        v.phase = W'(v_phase);
        v.smode = 2'(v_smode);
        v.evdiv = EW'(v_evdiv);
        v.car   = W'(e_car);
        v.dir   = 1'(e_dir);
        v.z     = 1'(e_z);
        v.m     = 1'(e_m);
        v.s     = 1'(e_s);
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [W+3:0] act, logic [W+3:0] exp);
        logic [W-1:0] a_car;
        logic [W-1:0] e_car;
        logic [3:0]   a_fl;
        logic [3:0]   e_fl;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            a_car = act[W+3:4];
            e_car = exp[W+3:4];
            a_fl  = act[3:0];
            e_fl  = exp[3:0];
            $display("FAIL %s: got carrier=%0d dir/zero/max/sync=%b, expected carrier=%0d dir/zero/max/sync=%b",
                     name, a_car, a_fl, e_car, e_fl);
        end
    endtask

    function automatic logic [W+3:0] outs();
        return {carrier, dir, zero_evt, max_evt, sync};
    endfunction

    initial begin
        rst_n      = 1'b0;
        ce         = 1'b0;
        countmax   = '0;
        count_mode = 2'b00;
        presc      = '0;
        phase      = '0;
        phase_ld   = 1'b0;
        sync_mode  = 2'b00;
        ev_div     = '0;

        //   tag      ce md cmax ps ld ph sm ed   car dir z m s
        add("idle",   1, 0, 3,   0, 0, 0, 1, 0,   0, 1, 0, 0, 0);
        // Up, countmax=3: start at 0, zero/max events, sync on every zero (ev_div=0)
        add("up",     1, 1, 3,   0, 0, 0, 1, 0,   0, 1, 0, 0, 0);
        add("up",     1, 1, 3,   0, 0, 0, 1, 0,   1, 1, 0, 0, 0);
        add("up",     1, 1, 3,   0, 0, 0, 1, 0,   2, 1, 0, 0, 0);
        add("up",     1, 1, 3,   0, 0, 0, 1, 0,   3, 1, 0, 1, 0);
        add("up",     1, 1, 3,   0, 0, 0, 1, 0,   0, 1, 1, 0, 1);
        add("up",     1, 1, 3,   0, 0, 0, 1, 0,   1, 1, 0, 0, 0);
        add("up",     1, 1, 3,   0, 0, 0, 1, 0,   2, 1, 0, 0, 0);
        add("up",     1, 1, 3,   0, 0, 0, 1, 0,   3, 1, 0, 1, 0);
        add("up",     1, 1, 3,   0, 0, 0, 1, 0,   0, 1, 1, 0, 1);
        add("stop",   1, 0, 3,   0, 0, 0, 1, 0,   0, 1, 0, 0, 0);
        // Up-down, countmax=4, both events selected, ev_div=1: sync on zero only
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   0, 1, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   1, 1, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   2, 1, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   3, 1, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   4, 1, 0, 1, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   3, 0, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   2, 0, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   1, 0, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   0, 0, 1, 0, 1);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   1, 1, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   2, 1, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   3, 1, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   4, 1, 0, 1, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   3, 0, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   2, 0, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   1, 0, 0, 0, 0);
        add("ud",     1, 3, 4,   0, 0, 0, 3, 1,   0, 0, 1, 0, 1);
        add("ud_nos", 1, 3, 4,   0, 0, 0, 0, 1,   1, 1, 0, 0, 0);
        add("ud_nos", 1, 3, 4,   0, 0, 0, 0, 1,   2, 1, 0, 0, 0);
        add("ud_nos", 1, 3, 4,   0, 0, 0, 0, 1,   3, 1, 0, 0, 0);
        add("ud_nos", 1, 3, 4,   0, 0, 0, 0, 1,   4, 1, 0, 1, 0);
        add("ud_nos", 1, 3, 4,   0, 0, 0, 0, 1,   3, 0, 0, 0, 0);
        add("ud_nos", 1, 3, 4,   0, 0, 0, 0, 1,   2, 0, 0, 0, 0);
        add("ud_nos", 1, 3, 4,   0, 0, 0, 0, 1,   1, 0, 0, 0, 0);
        add("ud_nos", 1, 3, 4,   0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
        add("stop",   1, 0, 4,   0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        // Up, countmax 5 -> 2 changed mid-period: takes effect after the wrap
        add("shadow", 1, 1, 5,   0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add("shadow", 1, 1, 5,   0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        add("shadow", 1, 1, 5,   0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        add("shadow", 1, 1, 2,   0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        add("shadow", 1, 1, 2,   0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
        add("shadow", 1, 1, 2,   0, 0, 0, 0, 0,   5, 1, 0, 1, 0);
        add("shadow", 1, 1, 2,   0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
        add("shadow", 1, 1, 2,   0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        add("shadow", 1, 1, 2,   0, 0, 0, 0, 0,   2, 1, 0, 1, 0);
        add("shadow", 1, 1, 2,   0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
        add("stop",   1, 0, 2,   0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        // Down, countmax=3, max events only, ev_div=2: sync on every third max
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   3, 0, 0, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   2, 0, 0, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   1, 0, 0, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   0, 0, 1, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   3, 0, 0, 1, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   2, 0, 0, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   1, 0, 0, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   0, 0, 1, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   3, 0, 0, 1, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   2, 0, 0, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   1, 0, 0, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   0, 0, 1, 0, 0);
        add("down",   1, 2, 3,   0, 0, 0, 2, 2,   3, 0, 0, 1, 1);
        add("stop",   1, 0, 3,   0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        // Up, countmax=7, presc=2; ce low for 5 cycles freezes carrier and prescaler
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            add("ce_off", 0, 1, 7, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        add("presc",  1, 1, 7,   2, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        // Phase preload: ignored with ce low, clamped to countmax, beats the tick, no event
        add("ld_ce0", 0, 1, 7,   0, 1, 5, 0, 0,   3, 1, 0, 0, 0);
        add("ld_clp", 1, 1, 7,   0, 1, 10, 0, 0,  7, 1, 0, 0, 0);
        add("ld",     1, 1, 7,   0, 0, 0, 0, 0,   0, 1, 1, 0, 0);
        add("ld",     1, 1, 7,   0, 1, 2, 0, 0,   2, 1, 0, 0, 0);
        add("ld",     1, 1, 7,   0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        add("stop",   1, 0, 7,   0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        // Up-down with countmax=1 toggles 0,1
        add("ud1",    1, 3, 1,   0, 0, 0, 0, 0,   0, 1, 0, 0, 0);
        add("ud1",    1, 3, 1,   0, 0, 0, 0, 0,   1, 1, 0, 1, 0);
        add("ud1",    1, 3, 1,   0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
        add("ud1",    1, 3, 1,   0, 0, 0, 0, 0,   1, 1, 0, 1, 0);
        add("ud1",    1, 3, 1,   0, 0, 0, 0, 0,   0, 0, 1, 0, 0);

        #12;
        check("reset", outs(), {W'(0), 4'b1000});
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            ce         = vecs[i].ce;
            count_mode = vecs[i].mode;
            countmax   = vecs[i].cmax;
            presc      = vecs[i].presc;
            phase_ld   = vecs[i].ld;
            phase      = vecs[i].phase;
            sync_mode  = vecs[i].smode;
            ev_div     = vecs[i].evdiv;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", vecs[i].tag, i), outs(),
                  {vecs[i].car, vecs[i].dir, vecs[i].z, vecs[i].m, vecs[i].s});
        end

        // Asynchronous reset between edges, while zero_evt is high and dir is 0
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), {W'(0), 4'b1000});
        count_mode = 2'b01;
        countmax   = W'(7);
        phase_ld   = 1'b0;
        #1;
        check("reset_held", outs(), {W'(0), 4'b1000});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_0", outs(), {W'(0), 4'b1000});
        @(posedge clk);
        #1;
        check("restart_1", outs(), {W'(1), 4'b1000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_carrier_gen.md
Name: pwm_carrier_gen

Overview:
Parametrised PWM carrier generator. Produces the up, down or up-down carrier that feeds the PWM comparators, plus zero/max events and a divided sync pulse.
Compared with the 16-bit timer it adds:
- a width parameter
- shadowed period and mode, loaded only at period boundaries
- a clock prescaler
- phase preload with clamping
- a configurable sync event divider
It sits between the AXI register bank and the comparator/dead-time stages.

Parameters:
WIDTH, 16, carrier/period width in bits
PRESC_WIDTH, 8, prescaler compare width
EVDIV_WIDTH, 4, sync event-divider width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ce  in  1  clock enable; when 0, all state is frozen and phase_ld is ignored
countmax  in  WIDTH  period peak value (shadowed)
count_mode  in  2  00 stop, 01 up, 10 down, 11 up-down (01/10/11 shadowed; 00 takes effect immediately)
presc  in  PRESC_WIDTH  carrier advances once every presc+1 ce cycles
phase  in  WIDTH  preload value
phase_ld  in  1  one-cycle pulse: load phase into carrier
sync_mode  in  2  00 none, 01 zero events, 10 max events, 11 both
ev_div  in  EVDIV_WIDTH  sync fires once per ev_div+1 selected events
carrier  out  WIDTH  carrier value (registered)
dir  out  1  1 = counting up, 0 = counting down
zero_evt  out  1  one-cycle pulse
max_evt  out  1  one-cycle pulse
sync  out  1  one-cycle pulse

Behaviour:
- Reset (rst_n low, asynchronous): carrier=0, dir=1, zero_evt=max_evt=sync=0, shadow countmax=0, shadow mode=00, prescaler and event counters cleared.
- STOP state:
  - Entered whenever live count_mode==00 or shadow countmax==0.
  - Holds carrier=0, dir=1; prescaler and event counters are cleared; no events are generated.
- STOP exit:
  - On the first ce cycle with count_mode!=00 and countmax!=0, both shadows load from the live inputs.
  - Carrier is set to 0 (up, up-down; dir=1) or to countmax (down; dir=0).
- tick: ce=1 and prescaler count==presc. The prescaler then restarts at 0; presc=0 gives a tick every ce cycle.
- Up mode: on each tick carrier+1; at carrier==countmax_sh the next tick wraps to 0. Period is countmax_sh+1 ticks.
- Down mode: on each tick carrier-1; at carrier==0 the next tick loads countmax_sh. Period is countmax_sh+1 ticks.
- Up-down mode: on each tick carrier moves in direction dir.
  - At countmax_sh, dir becomes 0 and the carrier decrements.
  - At 0, dir becomes 1 and the carrier increments.
  - Period is 2*countmax_sh ticks; countmax_sh==1 toggles 0,1.
- Shadow load:
  - countmax and count_mode (01/10/11) transfer to the shadows on the same tick that makes carrier become 0 (all modes).
  - The new values govern the following period; mid-period changes have no effect.
- phase_ld (with ce=1):
  - Next cycle carrier=min(phase, countmax_sh); dir is unchanged.
  - Prescaler is cleared.
  - Has priority over a coincident tick.
  - No event is generated by the load itself.
- Events:
  - zero_evt is high for exactly one clk cycle, coincident with the first cycle carrier==0 after a counting tick.
  - max_evt is the same for carrier==countmax_sh.
  - Events are not repeated while the carrier is held between ticks.
- sync:
  - A selected event increments the event counter.
  - When the counter equals ev_div, sync pulses coincident with that event and the counter clears.
  - sync_mode=00: sync stays 0 and the counter is held at 0.
  - Up-down mode with sync_mode=11 sees both events in one period.
- Arithmetic: unsigned WIDTH-bit values; no overflow is possible because the carrier is bounded by countmax_sh.
- Latency: carrier updates one clk after the tick; event pulses align with the updated carrier.

Decomposition:
- Shared package pwm_pkg:
  - count_mode encodings MODE_STOP/UP/DOWN/UPDOWN
  - sync_mode encodings SYNC_NONE/ZERO/MAX/BOTH
- One natural sub-module: pwm_prescaler (ce/presc in; tick out; synchronous clear input driven by STOP and phase_ld).

Test Plan:
- Up mode, countmax=3, presc=0 -> carrier 0,1,2,3,0,1…; zero_evt every 4 cycles; max_evt when carrier==3.
- Up-down mode, countmax=4 -> carrier 0,1,2,3,4,3,2,1,0; dir falls at 4; period 8 cycles.
- Up mode, countmax=5, change countmax to 2 while carrier=2 -> carrier continues to 5 and wraps; next period is 0,1,2.
- presc=2, up mode, countmax=7 -> carrier advances every 3 ce cycles; toggling ce low for 5 cycles freezes carrier, dir and prescaler.
- Up-down mode, countmax=4, sync_mode=11, ev_div=1 -> sync once per 8-cycle period, only on zero events (the 2nd event counted); sync_mode=00 -> sync never asserts.
- Up mode, countmax=7: phase_ld with phase=10 -> carrier=7. Separately, rst_n low mid-count -> carrier=0, dir=1, all outputs 0 immediately, before any clk edge.
